// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory access stage: FSM state encoding,
// the word-alignment mask and the default bus timeout.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } memState_t;

   localparam logic [1:0]  ALIGN_MASK      = 2'b11;
   localparam int unsigned DEFAULT_TIMEOUT = 16;

   // True when the two low address bits select a whole word.
   function automatic logic isAligned(input logic [1:0] lowAddr);
      return (lowAddr & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts REQ cycles that pass without a bus acknowledge and flags the last
// cycle before the access has to be abandoned.
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic atLimit
);

   logic [CNT_W-1:0] count;

   // Cycle counter: clear dominates, otherwise step once per enabled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Terminal count: this is the final cycle the request may wait.
   always_comb begin
      atLimit = (count == CNT_W'(TIMEOUT - 1));
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage behind the single-cycle datapath. Runs lw/sw on a
// req/ack bus, returns load data, stalls the PC until the access ends and
// reports misaligned addresses and bus timeouts as one-cycle pulses.
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] AluOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrErr,
   output logic        BusTmo,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   memState_t state;
   logic      memOp;
   logic      ctrClear;
   logic      ctrEnable;
   logic      ctrAtLimit;

   // Memory-instruction decode and timeout counter controls.
   always_comb begin
      memOp     = MemRead | MemWrite;
      ctrClear  = (state != ST_REQ);
      ctrEnable = (state == ST_REQ) & ~BusAck;
   end

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) uTimeoutCtr (
      .clk     (CLK),
      .rst     (Reset),
      .clear   (ctrClear),
      .enable  (ctrEnable),
      .atLimit (ctrAtLimit)
   );

   // Access FSM with registered bus, result and status outputs.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state    <= ST_IDLE;
         BusReq   <= 1'b0;
         BusWe    <= 1'b0;
         BusAddr  <= '0;
         BusWData <= '0;
         ReadData <= '0;
         AddrErr  <= 1'b0;
         BusTmo   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               AddrErr <= 1'b0;
               BusTmo  <= 1'b0;
               if (memOp) begin
                  if (!isAligned(AluOut[1:0])) begin
                     AddrErr  <= 1'b1;
                     ReadData <= '0;
                     state    <= ST_DONE;
                  end else begin
                     BusAddr  <= {AluOut[31:2], 2'b00};
                     BusWData <= WriteData;
                     BusWe    <= MemWrite;
                     BusReq   <= 1'b1;
                     state    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // An ack on the terminal cycle still completes the access.
               if (BusAck) begin
                  BusReq <= 1'b0;
                  if (!BusWe) begin
                     ReadData <= BusRData;
                  end
                  state <= ST_DONE;
               end else if (ctrAtLimit) begin
                  BusReq   <= 1'b0;
                  BusTmo   <= 1'b1;
                  ReadData <= '0;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               AddrErr <= 1'b0;
               BusTmo  <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               BusReq <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // PC/regfile hold: released in DONE so the instruction retires once.
   always_comb begin
      Stall = memOp & (state != ST_DONE);
   end

endmodule
